// File: rtl/instr_encoder.sv
// Turns decoded instruction fields into 32-bit words and writes them to
// sequential instruction-memory addresses, one word every three cycles.
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] imm,
  input  logic        last,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic        err,
  output logic        done,
  output logic        full
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  mnem_q, rs_q, rt_q;
  logic [15:0] imm_q;
  logic        last_q;

  logic        is_shift_imm;
  logic        word_ok;
  logic [5:0]  opcode;
  logic [4:0]  shamt;
  logic [31:0] word;

  // Encoding works only from the fields captured at the transfer edge.
  always_comb begin
    is_shift_imm = (mnem_q == 5'd4) || (mnem_q == 5'd5) || (mnem_q == 5'd8);
    word_ok      = (mnem_q <= 5'd25) && !(is_shift_imm && (imm_q > 16'd31));
    opcode       = (mnem_q < 5'd10) ? 6'd0 : ({1'b0, mnem_q} - 6'd9);
    shamt        = is_shift_imm ? imm_q[4:0] : 5'd0;
    if (opcode == 6'd0)
      word = {opcode, rs_q, rt_q, shamt, 6'd0, mnem_q};
    else
      word = {opcode, rs_q, rt_q, imm_q};
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) && !full;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = ENCODE;
      ENCODE:  state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mnem_q     <= 5'd0;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      imm_q      <= 16'd0;
      last_q     <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 10'd0;
      imem_wdata <= 32'd0;
      err        <= 1'b0;
      done       <= 1'b0;
      full       <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        mnem_q <= mnem;
        rs_q   <= rs;
        rt_q   <= rt;
        imm_q  <= imm;
        last_q <= last;
      end
      imem_we <= 1'b0;
      err     <= 1'b0;
      done    <= 1'b0;
      if (state == ENCODE) begin
        imem_we <= word_ok;
        err     <= !word_ok;
        done    <= word_ok && last_q;
        if (word_ok) imem_wdata <= word;
      end
      // The write pulse doubles as the "advance address" flag; no wrap at the top.
      if ((state == WRITE) && imem_we) begin
        if (imem_addr == 10'd1023) full      <= 1'b1;
        else                       imem_addr <= imem_addr + 10'd1;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: in_valid  input  1  instruction fields present.
REQ-004 SHALL have port: in_ready  output  1  encoder accepts fields this cycle.
REQ-005 SHALL have port: mnem  input  5  mnemonic index, table REQ-012.
REQ-006 SHALL have port: rs  input  5; rt  input  5  register fields.
REQ-007 SHALL have port: imm  input  16  immediate or shift amount.
REQ-008 SHALL have port: last  input  1  final instruction of program.
REQ-009 SHALL have ports: imem_we  output  1; imem_addr  output  10; imem_wdata  output  32  instruction-memory write port.
REQ-010 SHALL have ports: err  output  1; done  output  1; full  output  1  status.

Function
REQ-011 Transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_ready=1 only in state IDLE with full=0.
REQ-012 Mnemonic map SHALL be: mnem 0..9 -> opcode 0, opcode_ext=mnem (add, comp, and, xor, shll, shrl, shllv, shrlv, shra, shrav); mnem 10..25 -> opcode=mnem-9, opcode_ext unused (lw, sw, b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, call, ret, addi, compi).
REQ-013 Word layout SHALL be: [31:26] opcode, [25:21] rs, [20:16] rt.
REQ-014 For opcode 0 the word SHALL carry [15:11] shamt, [10:0] opcode_ext; shamt=imm[4:0] for mnem 4, 5, 8, else 0.
REQ-015 For opcode 1..16 the word SHALL carry [15:0]=imm unmodified.
REQ-016 States SHALL be IDLE, ENCODE, WRITE; transfer at edge k -> ENCODE; edge k+1 -> WRITE; edge k+2 -> IDLE.
REQ-017 Word and address SHALL be registered at edge k+1; imem_we=1 for exactly the one cycle between edges k+1 and k+2, with imem_addr and imem_wdata stable throughout.
REQ-018 imem_addr SHALL increment by 1 at edge k+2 after each write; throughput is one instruction per 3 cycles.
REQ-019 mnem>25, or mnem in {4,5,8} with imm>31, SHALL be invalid: no write, address unchanged, err=1 for the cycle between edges k+1 and k+2.
REQ-020 done SHALL be 1 in the same cycle as imem_we when the transferred word had last=1; an invalid word with last=1 SHALL raise err only, not done.
REQ-021 After the write at address 1023, full SHALL become 1 at edge k+2 and stay 1 until rst; imem_addr SHALL hold 1023 with no wrap, and in_ready=0.
REQ-022 in_valid during ENCODE or WRITE SHALL be ignored; input fields SHALL be sampled only at the transfer edge.

Reset
REQ-023 On rst=1 at an edge: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, err=0, done=0, full=0; in_ready SHALL become 1 in the following cycle.
REQ-024 rst in ENCODE or WRITE SHALL abort the operation; no imem_we pulse follows, and a pulse already in progress SHALL drop at that edge.
REQ-025 rst=1 SHALL take priority over a simultaneous transfer, which is discarded.

Verification
REQ-026 add, mnem=0, rs=1, rt=2 -> one imem_we pulse at addr 0, wdata=0x00220000, 2 edges after transfer.
REQ-027 shra, mnem=8, rs=3, rt=4, imm=5 -> wdata=0x00642808; then mnem=8, imm=40 -> err pulse, no write, addr stays 1.
REQ-028 addi, mnem=24, rs=5, rt=6, imm=0xFFFF, last=1 -> wdata=0x3CA6FFFF with done=1 in the imem_we cycle.
REQ-029 mnem=30 -> err=1 one cycle, imem_we never 1, addr unchanged.
REQ-030 Stream 1024 valid words -> full=1 after the 1024th write, addr=1023, in_ready=0, and a 1025th in_valid causes no write.
REQ-031 rst asserted in the WRITE cycle -> imem_we=0 from that edge, addr=0, in_ready=1 next cycle; next word is written at addr 0.
